// File: rtl/store_split_sequencer_pkg.sv
// Shared definitions for the store split sequencer: store funct3 codes,
// FSM state encoding and funct3 decode helpers.
package store_split_sequencer_pkg;

    // Store width codes, identical to FNC_SB/FNC_SH/FNC_SW in opcode.vh
    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    function automatic logic store_legal(input logic [2:0] f);
        return (f == FNC_SB) || (f == FNC_SH) || (f == FNC_SW);
    endfunction

    // Access size in bytes (1, 2 or 4); 0 for an illegal code.
    function automatic logic [2:0] store_bytes(input logic [2:0] f);
        logic [2:0] n;
        case (f)
            FNC_SB:  n = 3'd1;
            FNC_SH:  n = 3'd2;
            FNC_SW:  n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Places store data and byte enables into word lanes for the first or
// second beat of a (possibly word-crossing) store.
module store_lane_shift (
    input  logic [1:0]  off_i,
    input  logic [2:0]  nbytes_i,
    input  logic        beat1_i,
    input  logic [31:0] data_i,
    output logic [3:0]  wbe_o,
    output logic [31:0] din_o
);
    logic [3:0]  mask;
    logic [7:0]  mask_up;
    logic [2:0]  back;
    logic [31:0] din_raw;

    always_comb begin
        case (nbytes_i)
            3'd4:    mask = 4'b1111;
            3'd2:    mask = 4'b0011;
            3'd1:    mask = 4'b0001;
            default: mask = 4'b0000;
        endcase
        mask_up = {4'b0000, mask} << off_i;
        back    = 3'd4 - {1'b0, off_i};
        if (beat1_i) begin
            wbe_o   = mask >> back;
            din_raw = data_i >> {back, 3'b000};
        end else begin
            wbe_o   = mask_up[3:0];
            din_raw = data_i << {off_i, 3'b000};
        end
        // Zero every lane that is not written so stale rs2 bits never leak out
        din_o = din_raw & {{8{wbe_o[3]}}, {8{wbe_o[2]}}, {8{wbe_o[1]}}, {8{wbe_o[0]}}};
    end

endmodule

// File: rtl/store_split_sequencer.sv
// Turns SB/SH/SW requests into one or two word-aligned byte-masked write
// beats on the data-memory port, with registered outputs and event counters.
module store_split_sequencer
    import store_split_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_en,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wbe,
    output logic [31:0]       mem_din,
    output logic              illegal_store,
    output logic [31:0]       store_count,
    output logic [31:0]       split_count
);
    state_e            state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        n_q, n_d;
    logic [31:0]       data_q, data_d;
    logic              split_q, split_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wbe_q, mem_wbe_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       store_cnt_q, store_cnt_d;
    logic [31:0]       split_cnt_q, split_cnt_d;

    logic              final_beat, accept, load, complete, to_beat1;
    logic [2:0]        req_n;
    logic [1:0]        sh_off;
    logic [2:0]        sh_n;
    logic [31:0]       sh_data;
    logic [3:0]        sh_wbe;
    logic [31:0]       sh_din;

    // One shifter serves both a freshly accepted request (beat 0) and the
    // latched request advancing to its second beat.
    store_lane_shift u_shift (
        .off_i    (sh_off),
        .nbytes_i (sh_n),
        .beat1_i  (!load),
        .data_i   (sh_data),
        .wbe_o    (sh_wbe),
        .din_o    (sh_din)
    );

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        n_d         = n_q;
        data_d      = data_q;
        split_d     = split_q;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;
        mem_wbe_d   = mem_wbe_q;
        mem_din_d   = mem_din_q;
        store_cnt_d = store_cnt_q;
        split_cnt_d = split_cnt_q;

        req_n      = store_bytes(req_funct3);
        final_beat = (state_q == ST_BEAT1) || ((state_q == ST_BEAT0) && !split_q);
        complete   = final_beat && mem_gnt;
        to_beat1   = (state_q == ST_BEAT0) && split_q && mem_gnt;
        req_ready  = (state_q == ST_IDLE) || complete;
        accept     = req_valid && req_ready;
        load       = accept && store_legal(req_funct3);
        illegal_d  = accept && !store_legal(req_funct3);

        sh_off  = load ? req_addr[1:0] : off_q;
        sh_n    = load ? req_n         : n_q;
        sh_data = load ? req_data      : data_q;

        if (complete) begin
            store_cnt_d = store_cnt_q + 32'd1;
            if (split_q)
                split_cnt_d = split_cnt_q + 32'd1;
        end

        if (load) begin
            state_d    = ST_BEAT0;
            off_d      = req_addr[1:0];
            n_d        = req_n;
            data_d     = req_data;
            split_d    = ({2'b00, req_addr[1:0]} + {1'b0, req_n}) > 4'd4;
            mem_en_d   = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wbe_d  = sh_wbe;
            mem_din_d  = sh_din;
        end else if (to_beat1) begin
            state_d    = ST_BEAT1;
            mem_addr_d = mem_addr_q + ADDR_W'(4);
            mem_wbe_d  = sh_wbe;
            mem_din_d  = sh_din;
        end else if (complete) begin
            state_d    = ST_IDLE;
            mem_en_d   = 1'b0;
            mem_addr_d = '0;
            mem_wbe_d  = 4'b0000;
            mem_din_d  = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'd0;
            n_q         <= 3'd0;
            data_q      <= 32'd0;
            split_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wbe_q   <= 4'b0000;
            mem_din_q   <= 32'd0;
            illegal_q   <= 1'b0;
            store_cnt_q <= 32'd0;
            split_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            n_q         <= n_d;
            data_q      <= data_d;
            split_q     <= split_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wbe_q   <= mem_wbe_d;
            mem_din_q   <= mem_din_d;
            illegal_q   <= illegal_d;
            store_cnt_q <= store_cnt_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    assign mem_en        = mem_en_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wbe       = mem_wbe_q;
    assign mem_din       = mem_din_q;
    assign illegal_store = illegal_q;
    assign store_count   = store_cnt_q;
    assign split_count   = split_cnt_q;

endmodule

// File: tb/tb_store_split_sequencer.sv
// Directed bench for store_split_sequencer with hand-computed beat values.
module tb_store_split_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_en;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wbe;
    logic [31:0] mem_din;
    logic        illegal_store;
    logic [31:0] store_count;
    logic [31:0] split_count;

    int n_chk = 0;
    int n_err = 0;

    store_split_sequencer #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .mem_en        (mem_en),
        .mem_gnt       (mem_gnt),
        .mem_addr      (mem_addr),
        .mem_wbe       (mem_wbe),
        .mem_din       (mem_din),
        .illegal_store (illegal_store),
        .store_count   (store_count),
        .split_count   (split_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_funct3 = f;
        req_addr   = a;
        req_data   = d;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        chk({tag, "_en"}, mem_en, 1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_wbe"}, mem_wbe, w);
        chk({tag, "_din"}, mem_din, d);
    endtask

    initial begin
        rst = 1'b1;
        mem_gnt = 1'b0;
        req(0, 3'b000, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_en", mem_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wbe", mem_wbe, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_ill", illegal_store, 0);
        chk("rst_scnt", store_count, 0);
        chk("rst_pcnt", split_count, 0);

        // SB @2, one beat
        mem_gnt = 1'b1;
        req(1, 3'b000, 32'h2, 32'h12345678);
        tick();
        req_valid = 1'b0;
        beat("sb", 32'h0, 4'b0100, 32'h00780000);
        tick();
        chk("sb_idle", mem_en, 0);
        chk("sb_scnt", store_count, 1);
        chk("sb_pcnt", split_count, 0);

        // SH @3, split
        req(1, 3'b001, 32'h3, 32'h12345678);
        tick();
        req_valid = 1'b0;
        #1;
        beat("sh0", 32'h0, 4'b1000, 32'h78000000);
        chk("sh0_ready", req_ready, 0);
        tick();
        beat("sh1", 32'h4, 4'b0001, 32'h00000056);
        tick();
        chk("sh_scnt", store_count, 2);
        chk("sh_pcnt", split_count, 1);

        // SW @6 with grant withheld 3 cycles in beat 0
        mem_gnt = 1'b0;
        req(1, 3'b010, 32'h6, 32'h89ABCDEF);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            beat("swst", 32'h4, 4'b1100, 32'hCDEF0000);
            chk("swst_ready", req_ready, 0);
            tick();
        end
        mem_gnt = 1'b1;
        #1;
        beat("sw0", 32'h4, 4'b1100, 32'hCDEF0000);
        chk("sw0_ready", req_ready, 0);
        tick();
        beat("sw1", 32'h8, 4'b0011, 32'h000089AB);
        tick();
        chk("sw_scnt", store_count, 3);
        chk("sw_pcnt", split_count, 2);

        // SW at top of address space wraps to 0
        req(1, 3'b010, 32'hFFFFFFFD, 32'hA1B2C3D4);
        tick();
        req_valid = 1'b0;
        beat("wr0", 32'hFFFFFFFC, 4'b1110, 32'hB2C3D400);
        tick();
        beat("wr1", 32'h0, 4'b0001, 32'h000000A1);
        tick();
        chk("wr_scnt", store_count, 4);
        chk("wr_pcnt", split_count, 3);

        // illegal funct3
        req(1, 3'b011, 32'h40, 32'hDEADBEEF);
        #1;
        chk("ill_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("ill_pulse", illegal_store, 1);
        chk("ill_en", mem_en, 0);
        tick();
        chk("ill_drop", illegal_store, 0);
        chk("ill_en2", mem_en, 0);
        chk("ill_scnt", store_count, 4);
        chk("ill_pcnt", split_count, 3);

        // four back-to-back aligned SW under continuous grant
        req(1, 3'b010, 32'h10, 32'h11111111);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) req(1, 3'b010, 32'h10 + 32'(4 * (i + 1)), 32'h11111111 * 32'(i + 2));
            else req_valid = 1'b0;
            #1;
            beat("b2b", 32'h10 + 32'(4 * i), 4'b1111, 32'h11111111 * 32'(i + 1));
            chk("b2b_ready", req_ready, 1);
            tick();
        end
        chk("b2b_idle", mem_en, 0);
        chk("b2b_scnt", store_count, 8);

        // SH @0x22 ends exactly at the word boundary: no split
        req(1, 3'b001, 32'h22, 32'h0000BEEF);
        tick();
        req_valid = 1'b0;
        beat("edge", 32'h20, 4'b1100, 32'hBEEF0000);
        tick();
        chk("edge_idle", mem_en, 0);
        chk("edge_scnt", store_count, 9);
        chk("edge_pcnt", split_count, 3);

        // reset during beat 1 of a split SH
        req(1, 3'b001, 32'hB, 32'h0000CAFE);
        tick();
        req_valid = 1'b0;
        beat("rb0", 32'h8, 4'b1000, 32'hFE000000);
        tick();
        beat("rb1", 32'hC, 4'b0001, 32'h000000CA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rb_en", mem_en, 0);
        chk("rb_wbe", mem_wbe, 0);
        chk("rb_scnt", store_count, 0);
        chk("rb_pcnt", split_count, 0);
        chk("rb_ready", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
